// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO address-map constants, decode helpers and write-buffer entry layout
package mmio_pkg;

    localparam int REGION_SHIFT = 10;
    localparam logic [31:0] GPIO_BASE = 32'h0000_0400;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wbuf_entry_t;

    function automatic logic [31-REGION_SHIFT:0] region_idx(input logic [31:0] addr);
        return (32-REGION_SHIFT)'(addr >> REGION_SHIFT);
    endfunction

    function automatic logic [31:0] region_offset(input logic [31:0] addr);
        return addr & ((32'd1 << REGION_SHIFT) - 32'd1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: in-order storage FIFO; a separate count register tells full from empty
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // pointer and occupancy next state; pointers wrap naturally on AW bits
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_write_buffer.sv
// mmio_write_buffer: posted store buffer with 1 KiB region decode; optional MMIO_WBUF_ERRCNT_EN adds err_count
module mmio_write_buffer
    import mmio_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int NPER        = 4,
    parameter int BASE_REGION = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [31:0]     st_addr,
    input  logic [31:0]     st_data,
    input  logic [NPER-1:0] p_busy,
    output logic [NPER-1:0] p_w_en,
    output logic [31:0]     p_w_addr,
    output logic [31:0]     p_w_data,
    output logic            wbuf_empty,
    output logic            err
`ifdef MMIO_WBUF_ERRCNT_EN
    ,
    output logic [15:0]     err_count
`endif
);

    localparam int IW = NPER > 1 ? $clog2(NPER) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    wbuf_entry_t     wr_entry, head;
    logic            full, empty;
    logic [CW-1:0]   count;
    logic [31-REGION_SHIFT:0] idx;
    logic            mapped, pop;
    logic [NPER-1:0] p_w_en_q, p_w_en_d;
    logic [31:0]     p_w_addr_q, p_w_addr_d, p_w_data_q, p_w_data_d;
    logic            err_q, err_d;

    assign wr_entry = '{addr: st_addr, data: st_data};
    assign st_ready = !rst && !full;

    sync_fifo #(.WIDTH($bits(wbuf_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (st_valid && st_ready),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // decode the head entry; a negative index wraps to a large value and is unmapped
    always_comb begin
        idx        = region_idx(head.addr) - (32-REGION_SHIFT)'(BASE_REGION);
        mapped     = idx < (32-REGION_SHIFT)'(NPER) && head.addr[1:0] == 2'b00;
        pop        = !empty && (!mapped || !p_busy[idx[IW-1:0]]);
        p_w_en_d   = (pop && mapped) ? NPER'(1) << idx[IW-1:0] : '0;
        p_w_addr_d = (pop && mapped) ? region_offset(head.addr) : p_w_addr_q;
        p_w_data_d = (pop && mapped) ? head.data : p_w_data_q;
        err_d      = pop && !mapped;
    end

    // registered strobe, payload and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            p_w_en_q   <= '0;
            p_w_addr_q <= '0;
            p_w_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            p_w_en_q   <= p_w_en_d;
            p_w_addr_q <= p_w_addr_d;
            p_w_data_q <= p_w_data_d;
            err_q      <= err_d;
        end
    end

    assign p_w_en     = p_w_en_q;
    assign p_w_addr   = p_w_addr_q;
    assign p_w_data   = p_w_data_q;
    assign err        = err_q;
    assign wbuf_empty = count == '0 && p_w_en_q == '0;

`ifdef MMIO_WBUF_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    // saturating count of dropped stores
    always_comb begin
        err_count_d = (err_q && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    end

    // error counter register
    always_ff @(posedge clk) begin
        if (rst) err_count_q <= '0;
        else     err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
`endif

endmodule

// File: doc/mmio_write_buffer.md
Name: mmio_write_buffer

Overview:
- Posted-write buffer and address decoder between the core's store port and the memory-mapped peripherals (GPIO at 0x00000400 and later neighbours).
- Accepts 32-bit stores and queues them in a small in-order FIFO.
- Decodes each store into a 1 KiB region and issues a single-cycle write strobe with a region-relative offset to the selected peripheral.
- The core never stalls on a slow peripheral unless the buffer is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- NPER, 4, number of peripheral regions; bit i of p_w_en serves region BASE_REGION+i.
- BASE_REGION, 1, region index (addr[31:10]) of peripheral 0; 1 gives 0x400, which is GPIO.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  core presents a store
- st_ready  out  1  buffer can accept; store is taken when st_valid && st_ready
- st_addr  in  32  byte address of the store
- st_data  in  32  store data
- p_busy  in  NPER  per-peripheral "cannot accept write this cycle"
- p_w_en  out  NPER  one-hot, single-cycle write strobe
- p_w_addr  out  32  offset within the region, {22'b0, addr[9:0]}
- p_w_data  out  32  write data
- wbuf_empty  out  1  FIFO empty and no strobe pending; used for fences
- err  out  1  one-cycle pulse when an unmapped or misaligned store is dropped

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers and count go to 0; queued and in-flight stores are discarded.
  - p_w_en=0, p_w_addr=0, p_w_data=0, err=0.
  - st_ready=0 while rst is high.
  - wbuf_empty=1 from the first cycle after reset.
- Accept:
  - st_ready = !rst && (count < DEPTH).
  - st_ready never depends on a same-cycle pop, so a full FIFO with a concurrent pop still refuses the push.
- Decode (head entry, combinational):
  - region = addr[31:10]; idx = region - BASE_REGION.
  - The entry is mapped when 0 <= idx < NPER and addr[1:0] == 0.
  - Otherwise it is an error entry.
- Pop decision, each cycle with the FIFO non-empty:
  - Error entry: pop the entry and register err=1 for the next cycle. No p_w_en is asserted.
  - Mapped entry with p_busy[idx]=0: pop the entry and register p_w_en = 1<<idx, p_w_addr and p_w_data for the next cycle.
  - Mapped entry with p_busy[idx]=1: hold. The FIFO is not popped and outputs return to p_w_en=0.
- Ordering:
  - Strictly in order; a busy head blocks every later entry, including entries for other peripherals.
- Latency and throughput:
  - Handshake in cycle t gives a p_w_en pulse in cycle t+2 when the target is not busy.
  - Sustained throughput is 1 store per cycle.
- Outputs:
  - p_w_en, p_w_addr, p_w_data and err are registered.
  - p_w_en is high for exactly one cycle per pop.
  - p_w_addr and p_w_data hold their last value when idle.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- Pointer wrap-around: modulo DEPTH using log2(DEPTH) bits; a separate count register distinguishes full from empty.
- wbuf_empty = (count == 0) && (p_w_en == 0).

Optional Feature:
- Macro: MMIO_WBUF_ERRCNT_EN.
- When defined:
  - Adds output err_count [15:0].
  - err_count increments on every err pulse and saturates at 16'hFFFF.
  - err_count resets to 0.
- When undefined:
  - The port and counter are absent.
  - err still pulses as specified above.

Decomposition:
- Package mmio_pkg holds:
  - REGION_SHIFT=10
  - GPIO_BASE=32'h0000_0400
  - the region-index and offset-extraction helpers
  - the FIFO entry layout {addr[31:0], data[31:0]}
- Sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count; synchronous rst) holds the storage.
- mmio_write_buffer contains only the decode, the pop control and the output registers.

Test Plan:
- Store 0x400 = 0x000000A5 with all p_busy low -> p_w_en=4'b0001, p_w_addr=0, p_w_data=0xA5 in cycle t+2, high for exactly one cycle; wbuf_empty returns to 1.
- Back-to-back stores to 0x400, 0x800, 0xC00 with data 1, 2, 3 -> p_w_en = 0001, 0010, 0100 on three consecutive cycles with matching data; st_ready stays 1.
- Hold p_busy[0]=1 and issue 5 stores to 0x400 -> 4 stores accepted, then st_ready=0. Release busy -> 4 strobes on consecutive cycles in order, after which st_ready=1 and the 5th store is accepted.
- Store 0x00000000, 0x1400, then 0x402, followed by a valid store to 0x400 -> err pulses 3 times with no p_w_en; the valid store then strobes normally. With MMIO_WBUF_ERRCNT_EN defined, err_count=3.
- Assert rst for one cycle while 3 entries are queued and a strobe is pending -> all outputs 0 on the next cycle and no further strobes; the next store after reset is delivered normally.
- Busy head at region 1 with a queued store to region 2 and p_busy[1]=0 -> region 2 does not strobe before region 1; strict ordering holds.
